// File: rtl/sevenseg_readback.sv
// sevenseg_readback: recovers displayed hex digits from the active-low
// multiplexed seven-segment bus. Every sample of {AN,SEG} is filtered for
// stability, and each stable window is classified and decoded exactly once.
module sevenseg_readback #(
   parameter int NUM_DIGITS    = 4,
   parameter int STABLE_CYCLES = 4
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic [6:0]              SEG,
   input  logic [NUM_DIGITS-1:0]   AN,
   input  logic                    CLR_BAD,
   output logic [4*NUM_DIGITS-1:0] VALUE,
   output logic [NUM_DIGITS-1:0]   BLANK,
   output logic [NUM_DIGITS-1:0]   DIG_VALID,
   output logic                    UPDATE,
   output logic                    BAD,
   output logic [6:0]              BAD_CODE
);

   localparam int SW = NUM_DIGITS + 7;
   localparam int CW = $clog2(STABLE_CYCLES + 1);
   localparam logic [CW-1:0] C_SAT  = CW'(STABLE_CYCLES);
   localparam logic [CW-1:0] C_FIRE = CW'(STABLE_CYCLES - 1);

   logic [SW-1:0]           r_s_reg;
   logic [SW-1:0]           r_s_prev;
   logic [CW-1:0]           r_cnt;
   logic [4*NUM_DIGITS-1:0] r_value;
   logic [NUM_DIGITS-1:0]   r_blank;
   logic [NUM_DIGITS-1:0]   r_valid;
   logic                    r_update;
   logic                    r_bad;
   logic [6:0]              r_bad_code;

   logic [CW-1:0]           w_cnt_nxt;
   logic                    w_capture;
   logic [NUM_DIGITS-1:0]   w_an_act;
   logic [6:0]              w_seg;
   logic [3:0]              w_nzero;
   logic                    w_code_ok;
   logic [3:0]              w_nib;
   logic                    w_is_blank;
   logic                    w_wr;
   logic                    w_bad_cap;
   logic [4*NUM_DIGITS-1:0] w_value_nxt;
   logic [NUM_DIGITS-1:0]   w_blank_nxt;
   logic [NUM_DIGITS-1:0]   w_valid_nxt;
   logic                    w_changed;

   // Stability counter next value and capture strobe. The strobe is keyed on
   // the counter's next value so that STABLE_CYCLES=1 fires on the very cycle
   // a new sample differs from the previous one, and larger values fire once
   // as the count passes STABLE_CYCLES-1 (the counter saturates above it).
   always_comb begin
      w_cnt_nxt = '0;
      if (r_s_reg == r_s_prev) begin
         w_cnt_nxt = (r_cnt == C_SAT) ? C_SAT : r_cnt + 1'b1;
      end
      w_capture = (w_cnt_nxt == C_FIRE);
   end

   // Classify the captured enables and decode the segment pattern.
   always_comb begin
      w_an_act   = ~r_s_reg[SW-1:7];
      w_seg      = r_s_reg[6:0];
      w_nzero    = '0;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
         if (w_an_act[i]) w_nzero = w_nzero + 4'd1;
      end
      w_is_blank = (w_seg == 7'h7F);
      w_code_ok  = 1'b1;
      w_nib      = 4'h0;
      case (w_seg)
         7'h40: w_nib = 4'h0;
         7'h79: w_nib = 4'h1;
         7'h24: w_nib = 4'h2;
         7'h30: w_nib = 4'h3;
         7'h19: w_nib = 4'h4;
         7'h12: w_nib = 4'h5;
         7'h02: w_nib = 4'h6;
         7'h78: w_nib = 4'h7;
         7'h00: w_nib = 4'h8;
         7'h10: w_nib = 4'h9;
         7'h08: w_nib = 4'hA;
         7'h03: w_nib = 4'hB;
         7'h46: w_nib = 4'hC;
         7'h21: w_nib = 4'hD;
         7'h06: w_nib = 4'hE;
         7'h0E: w_nib = 4'hF;
         default: w_code_ok = 1'b0;
      endcase
      w_wr      = w_capture && (w_nzero == 4'd1) && (w_code_ok || w_is_blank);
      w_bad_cap = w_capture && ((w_nzero > 4'd1) ||
                               ((w_nzero == 4'd1) && !w_code_ok && !w_is_blank));
   end

   // Next digit-register contents; only the single enabled digit is touched.
   always_comb begin
      w_value_nxt = r_value;
      w_blank_nxt = r_blank;
      w_valid_nxt = r_valid;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
         if (w_wr && w_an_act[i]) begin
            if (w_is_blank) begin
               w_blank_nxt[i] = 1'b1;
            end else begin
               w_value_nxt[4*i +: 4] = w_nib;
               w_blank_nxt[i]        = 1'b0;
            end
            w_valid_nxt[i] = 1'b1;
         end
      end
      w_changed = ({w_value_nxt, w_blank_nxt, w_valid_nxt} !=
                   {r_value, r_blank, r_valid});
   end

   // Input sampling, filter state, digit registers and error flag.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_s_reg    <= '1;
         r_s_prev   <= '1;
         r_cnt      <= '0;
         r_value    <= '0;
         r_blank    <= '1;
         r_valid    <= '0;
         r_update   <= 1'b0;
         r_bad      <= 1'b0;
         r_bad_code <= 7'h7F;
      end else begin
         r_s_reg  <= {AN, SEG};
         r_s_prev <= r_s_reg;
         r_cnt    <= w_cnt_nxt;
         r_value  <= w_value_nxt;
         r_blank  <= w_blank_nxt;
         r_valid  <= w_valid_nxt;
         r_update <= w_wr && w_changed;
         if (w_bad_cap) begin
            r_bad      <= 1'b1;
            r_bad_code <= w_seg;
         end else if (CLR_BAD) begin
            r_bad <= 1'b0;
         end
      end
   end

   assign VALUE     = r_value;
   assign BLANK     = r_blank;
   assign DIG_VALID = r_valid;
   assign UPDATE    = r_update;
   assign BAD       = r_bad;
   assign BAD_CODE  = r_bad_code;

endmodule
